// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Turns an asynchronous two-channel quadrature pair (A/B) into a step +
//   direction interface with an integrated wrap-around position count.
//   Each channel is synchronised, then glitch-filtered; every filtered change
//   of the {A,B} state is decoded as an up step, a down step or an illegal
//   double-bit jump.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   a_in      in   quadrature channel A (asynchronous to clk)
//   b_in      in   quadrature channel B (asynchronous to clk)
//   clr       in   synchronous position clear (wins over a coincident step)
//   err_clr   in   synchronous clear of err (loses to a coincident illegal jump)
//   step      out  one-cycle pulse per legal transition
//   up        out  direction of the last legal step (1 = up)
//   position  out  step count, wraps modulo 2^POS_WIDTH
//   err       out  sticky flag: illegal double-bit transition seen
//
// Handshake note: there is no valid/ready interface here; step is a plain
// one-cycle qualifier for up/position on the same cycle.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int POS_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 clr,
    input  logic                 err_clr,
    output logic                 step,
    output logic                 up,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err
);

    localparam int FCW       = $clog2(FILT_CYCLES + 1);
    localparam int ARM_EDGES = SYNC_STAGES + FILT_CYCLES + 1;
    localparam int ACW       = $clog2(ARM_EDGES + 1);

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } move_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    // Bit 1 is channel A, bit 0 is channel B, so the vector reads as {A,B}.
    logic [1:0] synced;
    logic [1:0] filt;

    assign synced = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    // ------------------------------------------------------------------
    // Per-channel glitch filter: the synced level must differ from the
    // accepted level for FILT_CYCLES consecutive edges before it is taken.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < 2; ch++) begin : g_filt
        logic           filt_q;
        logic [FCW-1:0] cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                filt_q <= 1'b0;
                cnt    <= '0;
            end else if (synced[ch] == filt_q) begin
                cnt <= '0;
            end else if (cnt == FCW'(FILT_CYCLES - 1)) begin
                filt_q <= ~filt_q;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign filt[ch] = filt_q;
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [1:0]     filt_prev;
    logic [ACW-1:0] arm_cnt;
    logic           armed;
    move_t          move;

    // Decode stays off until the filters have had time to settle on the
    // levels present at reset release, so a non-00 start is not an error.
    assign armed = (arm_cnt == ACW'(ARM_EDGES));

    always_comb begin
        move = MOVE_NONE;
        if (armed) begin
            case ({filt_prev, filt})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MOVE_UP;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MOVE_DOWN;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: move = MOVE_ILLEGAL;
                default:                                move = MOVE_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_prev <= 2'b00;
            arm_cnt   <= '0;
            step      <= 1'b0;
            up        <= 1'b1;
            position  <= '0;
            err       <= 1'b0;
        end else begin
            filt_prev <= filt;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end

            step <= (move == MOVE_UP) || (move == MOVE_DOWN);

            if (move == MOVE_UP) begin
                up <= 1'b1;
            end else if (move == MOVE_DOWN) begin
                up <= 1'b0;
            end

            if (clr) begin
                position <= '0;
            end else if (move == MOVE_UP) begin
                position <= position + 1'b1;
            end else if (move == MOVE_DOWN) begin
                position <= position - 1'b1;
            end

            if (move == MOVE_ILLEGAL) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Testbench for quad_step_decoder: directed scenarios with fixed expectations
// plus a randomized run checked cycle by cycle against a behavioural model.
module tb_quad_step_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int PW   = 16;
  localparam int ARM  = SYNC + FILT + 1;
  localparam int LAT  = SYNC + FILT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic clr = 1'b0;
  logic err_clr = 1'b0;
  logic step;
  logic up;
  logic err;
  logic [PW-1:0] position;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  quad_step_decoder #(
    .SYNC_STAGES(SYNC),
    .FILT_CYCLES(FILT),
    .POS_WIDTH(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_in(a_in),
    .b_in(b_in),
    .clr(clr),
    .err_clr(err_clr),
    .step(step),
    .up(up),
    .position(position),
    .err(err)
  );

  // ---------------- reference model ----------------
  // Quadrature phase index: the up direction walks 00,10,11,01 in order.
  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  bit qa[$];
  bit qb[$];
  logic [1:0] m_filt;
  logic [1:0] m_prev;
  logic [1:0] m_sync;
  int m_run[2];
  int m_edges;
  int m_d;
  bit m_ill;
  logic m_step;
  logic m_up;
  logic m_err;
  logic [PW-1:0] m_pos;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < SYNC; i++) begin
        qa.push_back(1'b0);
        qb.push_back(1'b0);
      end
      m_filt = 2'b00;
      m_prev = 2'b00;
      m_run[0] = 0;
      m_run[1] = 0;
      m_edges = 0;
      m_step = 1'b0;
      m_up = 1'b1;
      m_err = 1'b0;
      m_pos = '0;
    end else begin
      m_step = 1'b0;
      m_ill = 1'b0;
      if (m_edges >= ARM && m_filt != m_prev) begin
        m_d = (gidx(m_filt) - gidx(m_prev) + 4) % 4;
        if (m_d == 1) begin
          m_step = 1'b1;
          m_up = 1'b1;
          m_pos = m_pos + 1'b1;
        end else if (m_d == 3) begin
          m_step = 1'b1;
          m_up = 1'b0;
          m_pos = m_pos - 1'b1;
        end else begin
          m_ill = 1'b1;
        end
      end
      if (clr) m_pos = '0;
      if (m_ill) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_prev = m_filt;
      m_sync = {qa[$], qb[$]};
      for (int c = 0; c < 2; c++) begin
        if (m_sync[c] != m_filt[c]) begin
          m_run[c]++;
          if (m_run[c] == FILT) begin
            m_filt[c] = ~m_filt[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      qa.push_front(a_in);
      void'(qa.pop_back());
      qb.push_front(b_in);
      void'(qb.pop_back());
      if (m_edges < ARM) m_edges++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL reset_up: got %b expected 1", up); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL reset_position: got %h expected 0000", position); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step !== 1'b0 || err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_up_sequence();
    logic [1:0] seq[4];
    int first;
    int nsteps;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    first = 0;
    nsteps = 0;
    for (int k = 0; k < 4; k++) begin
      {a_in, b_in} = seq[k];
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (step === 1'b1) begin
          nsteps++;
          if (k == 0 && first == 0) first = i;
        end
      end
    end
    checks++; if (first != LAT) begin errors++; $display("FAIL up_latency: got %0d expected %0d", first, LAT); end
    checks++; if (nsteps != 4) begin errors++; $display("FAIL up_steps: got %0d expected 4", nsteps); end
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL up_dir: got %b expected 1", up); end
    checks++; if (position !== 16'h0004) begin errors++; $display("FAIL up_position: got %h expected 0004", position); end
  endtask

  task automatic test_down_sequence();
    logic [1:0] seq[3];
    logic [PW-1:0] exp_pos[3];
    seq = '{2'b01, 2'b11, 2'b10};
    exp_pos = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL down_clr: got %h expected 0000", position); end
    for (int k = 0; k < 3; k++) begin
      {a_in, b_in} = seq[k];
      repeat (10) @(negedge clk);
      checks++; if (position !== exp_pos[k]) begin errors++; $display("FAIL down_position%0d: got %h expected %h", k, position, exp_pos[k]); end
      checks++; if (up !== 1'b0) begin errors++; $display("FAIL down_dir%0d: got %b expected 0", k, up); end
    end
    // back to 00 (one more down step) for the next scenario
    {a_in, b_in} = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    int nsteps;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    nsteps = 0;
    a_in = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    a_in = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    checks++; if (nsteps != 0) begin errors++; $display("FAIL glitch3_steps: got %0d expected 0", nsteps); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL glitch3_position: got %h expected 0000", position); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL glitch3_err: got %b expected 0", err); end
    nsteps = 0;
    a_in = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    a_in = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    checks++; if (nsteps != 2) begin errors++; $display("FAIL glitch4_steps: got %0d expected 2", nsteps); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL glitch4_position: got %h expected 0000", position); end
    checks++; if (up !== 1'b0) begin errors++; $display("FAIL glitch4_dir: got %b expected 0", up); end
  endtask

  task automatic test_illegal();
    int nsteps;
    nsteps = 0;
    {a_in, b_in} = 2'b11;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
    checks++; if (nsteps != 0) begin errors++; $display("FAIL illegal_steps: got %0d expected 0", nsteps); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL illegal_position: got %h expected 0000", position); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", err); end
    // err_clr lands on exactly the edge that decodes 11->00
    {a_in, b_in} = 2'b00;
    repeat (LAT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_clr_coincident: got %b expected 1", err); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL illegal_nostep: got %b expected 0", step); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clr_coincident();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      {a_in, b_in} = phase_of(k);
      repeat (10) @(negedge clk);
    end
    checks++; if (position !== 16'h0005) begin errors++; $display("FAIL clr_setup_position: got %h expected 0005", position); end
    {a_in, b_in} = 2'b11;
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL clr_coincident_position: got %h expected 0000", position); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL clr_coincident_step: got %b expected 1", step); end
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL clr_coincident_up: got %b expected 1", up); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nbad;
    int nsteps;
    // drive away from the reset values: pos 1 -> 0 -> FFFF, direction down
    {a_in, b_in} = 2'b01;
    repeat (10) @(negedge clk);
    {a_in, b_in} = 2'b11;
    repeat (10) @(negedge clk);
    {a_in, b_in} = 2'b10;
    repeat (10) @(negedge clk);
    checks++; if (position !== 16'hFFFF) begin errors++; $display("FAIL mid_setup_position: got %h expected ffff", position); end
    {a_in, b_in} = 2'b11;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL mid_reset_step: got %b expected 0", step); end
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL mid_reset_up: got %b expected 1", up); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL mid_reset_position: got %h expected 0000", position); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b expected 0", err); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nbad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (step !== 1'b0 || err !== 1'b0) nbad++;
    end
    checks++; if (nbad != 0) begin errors++; $display("FAIL arming_quiet: got %0d active cycles expected 0", nbad); end
    nsteps = 0;
    {a_in, b_in} = 2'b01;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (step === 1'b1) nsteps++; end
    checks++; if (nsteps != 1) begin errors++; $display("FAIL rearm_steps: got %0d expected 1", nsteps); end
    checks++; if (up !== 1'b1) begin errors++; $display("FAIL rearm_up: got %b expected 1", up); end
    checks++; if (position !== 16'h0001) begin errors++; $display("FAIL rearm_position: got %h expected 0001", position); end
  endtask

  task automatic test_random();
    logic [1:0] cur;
    logic [1:0] mask;
    int kind;
    int hold_n;
    int glitch_n;
    cur = {a_in, b_in};
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      mask = 2'b00;
      glitch_n = 0;
      if (kind < 4) cur = phase_of(gidx(cur) + 1);
      else if (kind < 7) cur = phase_of(gidx(cur) + 3);
      else if (kind < 8) cur = ~cur;
      else begin
        mask = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        glitch_n = $urandom_range(1, FILT - 1);
      end
      hold_n = glitch_n + $urandom_range(1, 14);
      for (int c = 0; c < hold_n; c++) begin
        {a_in, b_in} = (c < glitch_n) ? (cur ^ mask) : cur;
        clr = ($urandom_range(0, 19) == 0);
        err_clr = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        checks++; if (step !== m_step) begin errors++; $display("FAIL rand_step: got %b expected %b at %0t", step, m_step, $time); end
        checks++; if (up !== m_up) begin errors++; $display("FAIL rand_up: got %b expected %b at %0t", up, m_up, $time); end
        checks++; if (position !== m_pos) begin errors++; $display("FAIL rand_position: got %h expected %h at %0t", position, m_pos, $time); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err: got %b expected %b at %0t", err, m_err, $time); end
      end
    end
    clr = 1'b0;
    err_clr = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_up_sequence();
    test_down_sequence();
    test_glitch();
    test_illegal();
    test_clr_coincident();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
